rx_frame_sync: RTL and testbench
================================

Name: rx_frame_sync

Overview:
- Front-end receive stage directly upstream of the 64-bit shift buffer / packet register chain.
- Takes the raw, oversampled RF comparator output `rfin` and recovers bit timing from its transitions.
- Hunts for a programmable sync word (with bounded bit errors), then captures a fixed-length payload.
- Presents the payload as a parallel word with a single-cycle valid pulse, plus a per-bit strobe for shift-enable-style consumers.

Parameters:
- OSR, 8: clock cycles per bit. Must be ≥4 and even.
- SYNC_W, 16: sync word length in bits.
- SYNC_WORD, 16'hD391: expected sync pattern. MSB is received first.
- MAX_ERR, 1: maximum Hamming distance accepted as a sync match.
- PAYLOAD_BITS, 64: payload length captured after sync.
- LOS_BITS, 16: bit periods without any rfin edge before a payload is aborted.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- rfin, input, 1: raw asynchronous RF bit stream.
- en, input, 1: receive enable. 1 = RX mode; 0 = block held idle.
- bit_stb, output, 1: one-cycle pulse on each recovered-bit sample.
- bit_out, output, 1: recovered bit value. Valid when bit_stb = 1.
- sync_det, output, 1: one-cycle pulse when a sync match is accepted.
- pkt_data, output, PAYLOAD_BITS: last captured payload. First-received bit is the MSB.
- pkt_valid, output, 1: one-cycle pulse when pkt_data is updated.
- abort, output, 1: one-cycle pulse when a payload is dropped on loss of signal.
- busy, output, 1: high while in PAYLOAD state.

Behaviour:

Reset:
- All outputs 0; pkt_data = 0.
- State IDLE; all counters and shift registers cleared.
- The two-flop synchronizer resets to 0.

Input path:
- rfin passes through a 2-flop synchronizer to give rfin_s (2-cycle latency).
- An edge is rfin_s != its previous-cycle value.

Bit timing:
- phase counter runs 0..OSR-1 and wraps.
- On an edge cycle, phase <= 1 (the edge cycle counts as phase 0); otherwise phase increments mod OSR.
- bit_stb is asserted and bit_out is driven with rfin_s in the cycle where phase == OSR/2.
- bit_stb and bit_out are registered outputs.
- Timing recovery runs in SEARCH and PAYLOAD states only.

States:
- IDLE:
  - phase, fill, bit and LOS counters are held at 0; no strobes are generated.
  - en = 1 → SEARCH next cycle.
- SEARCH:
  - Each bit_stb shifts bit_out into sync_sr (SYNC_W wide, shift-left, new bit enters at LSB).
  - fill counts received bits, saturating at SYNC_W.
  - Match condition: fill == SYNC_W (including the bit just shifted) and popcount(sync_sr ^ SYNC_WORD) ≤ MAX_ERR.
  - On a match: sync_det pulses the cycle after that bit_stb, bit counter is cleared, and the state moves to PAYLOAD.
- PAYLOAD:
  - Each bit_stb shifts bit_out into pay_sr and increments the bit counter.
  - When the bit counter reaches PAYLOAD_BITS:
    - pkt_data <= pay_sr including the final bit.
    - pkt_valid pulses one cycle after the final bit_stb.
    - State → SEARCH, with fill = 0 and sync_sr = 0.
  - The LOS counter counts cycles without an edge and is cleared on every edge.
  - When the LOS counter reaches LOS_BITS*OSR:
    - abort pulses.
    - State → SEARCH with fill cleared.
    - pkt_data is unchanged and pkt_valid is not asserted.
- busy = 1 exactly while the state is PAYLOAD.

Boundary conditions:
- **en deasserted in any state:** IDLE next cycle. An in-flight payload is discarded silently (no abort, no pkt_valid). pkt_data retains its last value.
- **Final payload bit and LOS timeout in the same cycle:** packet completion wins; pkt_valid is asserted, abort is not.
- **Completion cycle:** while returning to SEARCH, that bit_stb is not also shifted into sync_sr. Back-to-back frames need a full new sync word.
- **Edge coinciding with phase == OSR/2:** phase resets and no strobe is issued that cycle; the next strobe occurs OSR/2 cycles later.
- **Sync-word-like pattern inside a payload:** ignored; no sync_det in PAYLOAD.
- **Counter widths:** bit counter is clog2(PAYLOAD_BITS+1) bits; LOS counter is clog2(LOS_BITS*OSR+1) bits. Neither counter wraps.
- **Asynchronous rst mid-frame:** returns all state and outputs to reset values immediately.

Test Plan:
1. **Clean frame:** OSR=8, en=1. Send 8 bits of 1010 preamble, then 16'hD391, then payload 64'h0123_4567_89AB_CDEF with exact 8-cycle bit periods. Expect exactly one sync_det, then pkt_valid with pkt_data = 64'h0123456789ABCDEF; bit_stb is periodic at 8 cycles.
2. **Sync bit errors:** Sync word 16'hD390 (1 error) → sync_det and packet captured. Sync word 16'hD392 (2 errors) → no sync_det, no pkt_valid, busy stays 0.
3. **Clock drift:** Bit periods of 7 and 9 cycles alternating across the payload 64'hFFFF_0000_AAAA_5555. Expect a correct pkt_data via edge re-alignment, with exactly 64 bit_stb pulses after sync_det.
4. **Loss of signal:** After sync plus 20 payload bits, hold rfin constant for 16*8 cycles. Expect an abort pulse; pkt_valid stays 0; pkt_data holds its previous value; a following clean frame is received correctly.
5. **en drop mid-payload:** Drop en for 1 cycle at payload bit 30. Expect busy → 0, no abort, no pkt_valid, and no bit_stb in IDLE; a re-sent full frame is then captured correctly.
6. **Asynchronous reset:** Assert rst asynchronously at payload bit 40. Expect all outputs 0 and pkt_data = 0 immediately; after release with en=1, a new frame is captured correctly.

Source files
------------

// File: rtl/rx_frame_sync.sv
// Receive front end: resynchronises the oversampled rfin stream, recovers bit
// timing from its transitions, hunts for the sync word and captures one payload.
module rx_frame_sync #(
  parameter int                OSR          = 8,
  parameter int                SYNC_W       = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = 16'hD391,
  parameter int                MAX_ERR      = 1,
  parameter int                PAYLOAD_BITS = 64,
  parameter int                LOS_BITS     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rfin,
  input  logic                    en,
  output logic                    bit_stb,
  output logic                    bit_out,
  output logic                    sync_det,
  output logic [PAYLOAD_BITS-1:0] pkt_data,
  output logic                    pkt_valid,
  output logic                    abort,
  output logic                    busy
);

  localparam int PH_W    = $clog2(OSR);
  localparam int FILL_W  = $clog2(SYNC_W + 1);
  localparam int BC_W    = $clog2(PAYLOAD_BITS + 1);
  localparam int LOS_MAX = LOS_BITS * OSR;
  localparam int LOS_W   = $clog2(LOS_MAX + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, PAYLOAD} state_t;

  state_t                  state, state_nx;
  logic [1:0]              sync_ff;
  logic                    rfin_s, rfin_d, rfin_edge;
  logic [PH_W-1:0]         phase;
  logic                    stb_c;
  logic [SYNC_W-1:0]       sync_sr, sync_nx, sync_diff;
  logic [FILL_W-1:0]       fill, fill_nx;
  logic [FILL_W-1:0]       err_cnt;
  logic                    match;
  logic [PAYLOAD_BITS-1:0] pay_sr, pay_nx;
  logic [BC_W-1:0]         bit_cnt, bit_nx;
  logic                    done;
  logic [LOS_W-1:0]        los_cnt, los_nx;
  logic                    los_hit;
  logic                    sync_hit, pkt_done, los_abort;

  // Two-flop synchroniser plus one more stage for transition detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
      rfin_d  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], rfin};
      rfin_d  <= rfin_s;
    end
  end

  assign rfin_s    = sync_ff[1];
  assign rfin_edge = rfin_s ^ rfin_d;

  // An edge cycle is phase 0, so the sample lands mid-bit OSR/2 cycles later
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           phase <= '0;
    else if (state == IDLE)            phase <= '0;
    else if (rfin_edge)                phase <= PH_W'(1);
    else if (phase == PH_W'(OSR - 1))  phase <= '0;
    else                               phase <= phase + 1'b1;
  end

  assign stb_c = en && (state != IDLE) && !rfin_edge && (phase == PH_W'(OSR / 2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_stb <= 1'b0;
      bit_out <= 1'b0;
    end else begin
      bit_stb <= stb_c;
      bit_out <= stb_c & rfin_s;
    end
  end

  always_comb begin
    sync_nx   = {sync_sr[SYNC_W-2:0], bit_out};
    fill_nx   = (fill == FILL_W'(SYNC_W)) ? fill : fill + 1'b1;
    sync_diff = sync_nx ^ SYNC_WORD;
    err_cnt   = '0;
    for (int i = 0; i < SYNC_W; i++) err_cnt = err_cnt + FILL_W'(sync_diff[i]);
    match     = (fill_nx == FILL_W'(SYNC_W)) && (err_cnt <= FILL_W'(MAX_ERR));
    pay_nx    = {pay_sr[PAYLOAD_BITS-2:0], bit_out};
    bit_nx    = bit_cnt + 1'b1;
    done      = bit_stb && (bit_nx == BC_W'(PAYLOAD_BITS));
    los_nx    = rfin_edge ? '0 : ((los_cnt == LOS_W'(LOS_MAX)) ? los_cnt : los_cnt + 1'b1);
    los_hit   = (los_nx == LOS_W'(LOS_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!en) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    state_nx = SEARCH;
        SEARCH:  if (bit_stb && match) state_nx = PAYLOAD;
        PAYLOAD: if (done || los_hit) state_nx = SEARCH;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Completion outranks loss of signal when both land in the same cycle
  always_comb begin
    sync_hit  = en && (state == SEARCH) && bit_stb && match;
    pkt_done  = en && (state == PAYLOAD) && done;
    los_abort = en && (state == PAYLOAD) && !done && los_hit;
    busy      = (state == PAYLOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_det  <= 1'b0;
      pkt_valid <= 1'b0;
      abort     <= 1'b0;
      pkt_data  <= '0;
      sync_sr   <= '0;
      fill      <= '0;
      pay_sr    <= '0;
      bit_cnt   <= '0;
      los_cnt   <= '0;
    end else begin
      sync_det  <= sync_hit;
      pkt_valid <= pkt_done;
      abort     <= los_abort;
      if (pkt_done) pkt_data <= pay_nx;

      // Completion clears the hunt window so back-to-back frames need a full sync word
      if (state == IDLE || pkt_done) begin
        sync_sr <= '0;
        fill    <= '0;
      end else if (los_abort) begin
        fill    <= '0;
      end else if (state == SEARCH && bit_stb) begin
        sync_sr <= sync_nx;
        fill    <= fill_nx;
      end

      if (state == PAYLOAD && bit_stb) pay_sr <= pay_nx;

      if (state != PAYLOAD) bit_cnt <= '0;
      else if (bit_stb)     bit_cnt <= bit_nx;

      if (state != PAYLOAD) los_cnt <= '0;
      else                  los_cnt <= los_nx;
    end
  end

endmodule

// File: tb/tb_rx_frame_sync.sv
// Randomised frame-level bench: a bit-stream reference model predicts sync, packet
// and abort events into a queue that a negedge monitor drains against the DUT.
module tb_rx_frame_sync;
  localparam int          OSR     = 8;
  localparam int          SYNC_W  = 16;
  localparam logic [15:0] SW      = 16'hD391;
  localparam int          MAX_ERR = 1;
  localparam int          PAY     = 64;
  localparam int          FRAME   = 8 + SYNC_W + PAY;

  logic clk = 1'b0, rst, rfin, en;
  logic bit_stb, bit_out, sync_det, pkt_valid, abort, busy;
  logic [PAY-1:0] pkt_data;

  rx_frame_sync #(.OSR(OSR), .SYNC_W(SYNC_W), .SYNC_WORD(SW), .MAX_ERR(MAX_ERR),
                  .PAYLOAD_BITS(PAY), .LOS_BITS(16)) dut (
    .clk(clk), .rst(rst), .rfin(rfin), .en(en), .bit_stb(bit_stb), .bit_out(bit_out),
    .sync_det(sync_det), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .abort(abort),
    .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int kind; logic [63:0] data; } ev_t;  // kind: 0 sync, 1 packet, 2 abort
  ev_t         exp_q[$];
  int          n_checks = 0, n_fail = 0;
  int          cyc = 0, last_stb_cyc = -1, stb_in_pay = 0, model_syncs = 0;
  bit          exact_timing = 1'b1, busy_seen = 1'b0;
  logic [63:0] exp_pkt = '0;
  bit          fb[$];

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pops one expected event for every event pulse the DUT presents
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_seen = 1'b1;
      if (bit_stb && busy) begin
        stb_in_pay++;
        if (exact_timing && last_stb_cyc >= 0) check("bit_stb period", 64'(cyc - last_stb_cyc), 64'(OSR));
      end
      if (bit_stb) last_stb_cyc = cyc;
      if (sync_det || pkt_valid || abort) begin
        int kind;
        ev_t e;
        kind = sync_det ? 0 : (pkt_valid ? 1 : 2);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected event: got kind %0d, expected none (t=%0t)", kind, $time);
        end else begin
          e = exp_q.pop_front();
          check("event kind", 64'(kind), 64'(e.kind));
          if (kind == 1) begin
            check("pkt_data", pkt_data, e.data);
            check("payload strobes", 64'(stb_in_pay), 64'(PAY));
          end
        end
      end
      if (sync_det) stb_in_pay = 0;
    end
  end

  // Reference: slide a window over the received bit stream; a close-enough window
  // starts a payload of the next PAY bits, after which the hunt restarts from empty.
  function automatic void model(input bit bits[$], input bit tail_abort);
    int i = 0, start = 0;
    ev_t e;
    model_syncs = 0;
    while (i < bits.size()) begin
      if (i - start >= SYNC_W - 1) begin
        int h = 0;
        for (int k = 0; k < SYNC_W; k++) h += (bits[i-SYNC_W+1+k] != SW[SYNC_W-1-k]) ? 1 : 0;
        if (h <= MAX_ERR) begin
          e.kind = 0; e.data = '0; exp_q.push_back(e); model_syncs++;
          if (i + PAY <= bits.size() - 1) begin
            e.kind = 1; e.data = '0;
            for (int k = 1; k <= PAY; k++) e.data = {e.data[62:0], bits[i+k]};
            exp_q.push_back(e);
            exp_pkt = e.data;
            i = i + PAY + 1;
            start = i;
            continue;
          end else begin
            // Line goes quiet before the payload ends
            if (tail_abort) begin e.kind = 2; e.data = '0; exp_q.push_back(e); end
            return;
          end
        end
      end
      i++;
    end
  endfunction

  function automatic bit long_run(input bit first, input logic [63:0] d);
    int run = 1;
    bit prev = first;
    for (int i = 63; i >= 0; i--) begin
      run = (d[i] == prev) ? run + 1 : 1;
      prev = d[i];
      if (run >= 12) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [63:0] rand_pay(input bit lastb);
    logic [63:0] d;
    do d = {$urandom(), $urandom()}; while (long_run(lastb, d));
    return d;
  endfunction

  task automatic make_frame(input logic [15:0] sw, input logic [63:0] pay);
    fb = {};
    for (int i = 0; i < 8; i++) fb.push_back((i % 2) == 0);
    for (int i = SYNC_W - 1; i >= 0; i--) fb.push_back(sw[i]);
    for (int i = PAY - 1; i >= 0; i--) fb.push_back(pay[i]);
  endtask

  task automatic push_model(input int nbits, input bit tail_abort);
    bit mq[$];
    for (int i = 0; i < SYNC_W; i++) mq.push_back(1'b0);
    for (int i = 0; i < nbits; i++) mq.push_back(fb[i]);
    model(mq, tail_abort);
  endtask

  task automatic hold(input int ncyc);
    repeat (ncyc) begin @(posedge clk); #1; end
  endtask

  // Drifted payload bits alternate 7 and 9 cycles, averaging OSR
  task automatic tx(input int from, input int to, input bit drift);
    for (int i = from; i < to; i++) begin
      rfin = fb[i];
      hold((drift && i >= 8 + SYNC_W) ? ((i % 2) ? 9 : 7) : OSR);
    end
  endtask

  task automatic gap(input int nbits);
    rfin = 1'b0;
    hold(nbits * OSR);
  endtask

  task automatic run_frame(input logic [15:0] sw, input logic [63:0] pay, input bit drift);
    make_frame(sw, pay);
    busy_seen = 1'b0;
    push_model(FRAME, 1'b0);
    exact_timing = !drift;
    tx(0, FRAME, drift);
    gap(20);
    exact_timing = 1'b1;
    check("busy seen", 64'(busy_seen), 64'(model_syncs != 0));
    check("events drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " bit_stb"}, 64'(bit_stb), 64'd0);
    check({tag, " bit_out"}, 64'(bit_out), 64'd0);
    check({tag, " sync_det"}, 64'(sync_det), 64'd0);
    check({tag, " pkt_valid"}, 64'(pkt_valid), 64'd0);
    check({tag, " abort"}, 64'(abort), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " pkt_data"}, pkt_data, 64'd0);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    rst = 1'b1; en = 1'b0; rfin = 1'b0;
    hold(3);
    check_outputs_zero("reset");
    rst = 1'b0; en = 1'b1;
    gap(20);

    // Clean frames: fixed vector then random payloads
    run_frame(SW, 64'h0123_4567_89AB_CDEF, 1'b0);
    for (int n = 0; n < 3; n++) run_frame(SW, rand_pay(SW[0]), 1'b0);

    // One sync bit wrong is accepted, two are not
    run_frame(16'hD390, rand_pay(1'b0), 1'b0);
    run_frame(16'hD392, 64'h0, 1'b0);

    // Drift. Same runs as FFFF_0000_AAAA_5555, ordered so the sync word's trailing 1
    // does not stretch a 16-bit run past the loss-of-signal limit.
    run_frame(SW, 64'h0000_FFFF_5555_AAAA, 1'b1);

    // Loss of signal after 20 payload bits
    p = rand_pay(SW[0]);
    make_frame(SW, p);
    push_model(8 + SYNC_W + 20, 1'b1);
    tx(0, 8 + SYNC_W + 20, 1'b0);
    hold(16 * OSR + 40);
    check("abort drained", 64'(exp_q.size()), 64'd0);
    check("pkt_data kept after abort", pkt_data, exp_pkt);
    gap(20);
    run_frame(SW, rand_pay(SW[0]), 1'b0);

    // en dropped for one cycle at payload bit 30; tail zeros keep the rest sync-free
    p = rand_pay(SW[0]);
    p[31:0] = '0;
    make_frame(SW, p);
    push_model(8 + SYNC_W, 1'b0);
    tx(0, 8 + SYNC_W + 30, 1'b0);
    en = 1'b0;
    hold(1);
    check("en drop busy", 64'(busy), 64'd0);
    check("en drop bit_stb", 64'(bit_stb), 64'd0);
    en = 1'b1;
    tx(8 + SYNC_W + 30, FRAME, 1'b0);
    gap(20);
    check("en drop drained", 64'(exp_q.size()), 64'd0);
    check("pkt_data kept after en drop", pkt_data, exp_pkt);
    run_frame(SW, rand_pay(SW[0]), 1'b0);

    // Asynchronous reset at payload bit 40
    make_frame(SW, rand_pay(SW[0]));
    push_model(8 + SYNC_W, 1'b0);
    tx(0, 8 + SYNC_W + 40, 1'b0);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async reset");
    exp_pkt = '0;
    rfin = 1'b0;
    hold(3);
    rst = 1'b0;
    gap(20);
    run_frame(SW, rand_pay(SW[0]), 1'b0);

    check("final queue empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
